multi_tap_cup_simulator: RTL and testbench

//  Parametrised ear-cup acoustic model for closed-loop ANC simulation. Keeps a circular history of ambient

---
 rtl/multi_tap_cup_if.sv | 35 +++
 rtl/multi_tap_cup_simulator.sv | 178 +++++++++++++++++
 tb/tb_multi_tap_cup_simulator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_tap_cup_if.sv
// Sample/config/result bundle between the ANC testbench or host and the ear-cup model.
// The master drives samples and tap configuration; the slave (the model) returns feedback and status.
interface multi_tap_cup_if #(
    parameter int WIDTH     = 16,
    parameter int NUM_TAPS  = 4,
    parameter int MAX_DELAY = 256,
    parameter int SCALE_W   = 7
);
    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int DLY_W = $clog2(MAX_DELAY);

    logic                      ready_in;
    logic signed [WIDTH-1:0]   ambient_sample_in;
    logic signed [WIDTH-1:0]   speaker_output_in;
    logic                      cfg_we_in;
    logic [TAP_W-1:0]          cfg_tap_in;
    logic [DLY_W-1:0]          cfg_delay_in;
    logic signed [SCALE_W-1:0] cfg_scale_in;
    logic signed [WIDTH-1:0]   feedback_sample_out;
    logic                      done_out;
    logic                      busy_out;
    logic                      overrun_out;

    modport master (
        output ready_in, ambient_sample_in, speaker_output_in,
        output cfg_we_in, cfg_tap_in, cfg_delay_in, cfg_scale_in,
        input  feedback_sample_out, done_out, busy_out, overrun_out
    );

    modport slave (
        input  ready_in, ambient_sample_in, speaker_output_in,
        input  cfg_we_in, cfg_tap_in, cfg_delay_in, cfg_scale_in,
        output feedback_sample_out, done_out, busy_out, overrun_out
    );
endinterface

// File: rtl/multi_tap_cup_simulator.sv
// Ear-cup acoustic model: sums NUM_TAPS delayed, scaled copies of the ambient history,
// adds the speaker sample and saturates to produce the feedback-mic sample.
module multi_tap_cup_simulator #(
    parameter int WIDTH     = 16,
    parameter int NUM_TAPS  = 4,
    parameter int MAX_DELAY = 256,
    parameter int SCALE_W   = 7
) (
    input  logic              clk_in,
    input  logic              reset_in,
    multi_tap_cup_if.slave    bus
);
    localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int DLY_W  = $clog2(MAX_DELAY);
    localparam int PROD_W = WIDTH + SCALE_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS) + 1;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0]   SAT_MAX  = (SUM_W'(1) <<< (WIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0]   SAT_MIN  = -SAT_MAX - SUM_W'(1);
    localparam logic signed [SCALE_W-1:0] GAIN_MAX = SCALE_W'(32);
    localparam logic signed [SCALE_W-1:0] GAIN_MIN = -GAIN_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_TAP   = 2'd2,
        S_SUM   = 2'd3
    } state_t;

    logic signed [WIDTH-1:0]   hist_mem [MAX_DELAY];
    logic signed [WIDTH-1:0]   rd_data_q;

    state_t                    state_q;
    logic [DLY_W-1:0]          wr_ptr_q;
    logic [DLY_W:0]            fill_q;
    logic [DLY_W-1:0]          delay_q [NUM_TAPS];
    logic signed [SCALE_W-1:0] scale_q [NUM_TAPS];
    logic signed [WIDTH-1:0]   amb_q;
    logic signed [WIDTH-1:0]   spk_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      mac_en_q;
    logic signed [SCALE_W-1:0] mac_scale_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [WIDTH-1:0]   fb_q;
    logic                      done_q;
    logic                      busy_q;
    logic                      ovr_q;

    logic [TAP_W-1:0]          tap_sel_d;
    logic                      tap_live_d;
    logic [DLY_W-1:0]          rd_addr_d;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [WIDTH-1:0]   sat_d;
    logic signed [SCALE_W-1:0] gain_d;
    logic                      cfg_ok_d;

    // Tap selection and read address; a tap older than the filled history is masked off.
    always_comb begin
        tap_sel_d = '0;
        if (cnt_q < CNT_W'(NUM_TAPS)) begin
            tap_sel_d = TAP_W'(cnt_q);
        end else begin
            tap_sel_d = '0;
        end
        rd_addr_d  = wr_ptr_q - delay_q[tap_sel_d];
        tap_live_d = (cnt_q < CNT_W'(NUM_TAPS)) && ({1'b0, delay_q[tap_sel_d]} < fill_q);
    end

    assign prod_d = PROD_W'(rd_data_q) * PROD_W'(mac_scale_q);
    assign sum_d  = SUM_W'(acc_q >>> 5) + SUM_W'(spk_q);

    // Output saturation and config gain clamp.
    always_comb begin
        sat_d = '0;
        if (sum_d > SAT_MAX) begin
            sat_d = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sum_d < SAT_MIN) begin
            sat_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_d = sum_d[WIDTH-1:0];
        end
        gain_d = bus.cfg_scale_in;
        if (bus.cfg_scale_in > GAIN_MAX) begin
            gain_d = GAIN_MAX;
        end else if (bus.cfg_scale_in < GAIN_MIN) begin
            gain_d = GAIN_MIN;
        end else begin
            gain_d = bus.cfg_scale_in;
        end
        cfg_ok_d = ({1'b0, bus.cfg_tap_in} < (TAP_W + 1)'(NUM_TAPS));
    end

    // History RAM: not reset, stale contents are hidden by the fill count.
    always_ff @(posedge clk_in) begin
        if (state_q == S_WRITE) begin
            hist_mem[wr_ptr_q] <= amb_q;
        end
        rd_data_q <= hist_mem[rd_addr_d];
    end

    // Control FSM, tap table, MAC and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            amb_q       <= '0;
            spk_q       <= '0;
            cnt_q       <= '0;
            mac_en_q    <= 1'b0;
            mac_scale_q <= '0;
            acc_q       <= '0;
            fb_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                delay_q[k] <= (k == 0) ? DLY_W'(64) : '0;
                scale_q[k] <= (k == 0) ? SCALE_W'(16) : '0;
            end
        end else begin
            done_q <= 1'b0;
            ovr_q  <= bus.ready_in && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (bus.ready_in) begin
                        amb_q   <= bus.ambient_sample_in;
                        spk_q   <= bus.speaker_output_in;
                        busy_q  <= 1'b1;
                        state_q <= S_WRITE;
                    end else if (bus.cfg_we_in && cfg_ok_d) begin
                        delay_q[bus.cfg_tap_in] <= bus.cfg_delay_in;
                        scale_q[bus.cfg_tap_in] <= gain_d;
                    end
                end
                S_WRITE: begin
                    if (fill_q < (DLY_W + 1)'(MAX_DELAY)) begin
                        fill_q <= fill_q + (DLY_W + 1)'(1);
                    end
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    mac_en_q <= 1'b0;
                    state_q  <= S_TAP;
                end
                S_TAP: begin
                    // Read for tap cnt is issued while the previous tap's data is accumulated.
                    if (mac_en_q) begin
                        acc_q <= acc_q + ACC_W'(prod_d);
                    end
                    mac_en_q    <= tap_live_d;
                    mac_scale_q <= scale_q[tap_sel_d];
                    cnt_q       <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_TAPS)) begin
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    fb_q     <= sat_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    wr_ptr_q <= wr_ptr_q + DLY_W'(1);
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.feedback_sample_out = fb_q;
    assign bus.done_out            = done_q;
    assign bus.busy_out            = busy_q;
    assign bus.overrun_out         = ovr_q;
endmodule

// File: tb/tb_multi_tap_cup_simulator.sv
// Directed bench for the ear-cup model with a reference model feeding an expected-result queue.
module tb_multi_tap_cup_simulator;
    localparam int W  = 16;
    localparam int NT = 4;
    localparam int MD = 256;
    localparam int SW = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_tap_cup_if #(.WIDTH(W), .NUM_TAPS(NT), .MAX_DELAY(MD), .SCALE_W(SW)) bus ();

    multi_tap_cup_simulator #(.WIDTH(W), .NUM_TAPS(NT), .MAX_DELAY(MD), .SCALE_W(SW)) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    longint hist [MD];
    int     fill;
    int     wp;
    int     tdel [NT];
    int     tscl [NT];
    longint exp_q [$];

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        fill = 0;
        wp   = 0;
        for (int k = 0; k < NT; k++) begin
            tdel[k] = 0;
            tscl[k] = 0;
        end
        tdel[0] = 64;
        tscl[0] = 16;
        exp_q.delete();
    endfunction

    function automatic longint model_step(input longint amb, input longint spk);
        longint acc;
        longint r;
        hist[wp] = amb;
        if (fill < MD) fill++;
        acc = 0;
        for (int k = 0; k < NT; k++)
            if (tdel[k] < fill) acc += hist[(wp - tdel[k] + MD) % MD] * tscl[k];
        r = (acc >>> 5) + spk;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        wp = (wp + 1) % MD;
        return r;
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.ready_in  = 1'b0;
        bus.cfg_we_in = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rst_feedback"}, bus.feedback_sample_out, 0);
        check({tag, "_rst_done"}, bus.done_out, 0);
        check({tag, "_rst_busy"}, bus.busy_out, 0);
        check({tag, "_rst_overrun"}, bus.overrun_out, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cfg(input int k, input int d, input int s);
        bus.cfg_we_in    = 1'b1;
        bus.cfg_tap_in   = 2'(k);
        bus.cfg_delay_in = 8'(d);
        bus.cfg_scale_in = 7'(s);
        @(posedge clk); #1;
        bus.cfg_we_in = 1'b0;
        tdel[k] = d;
        tscl[k] = (s > 32) ? 32 : ((s < -32) ? -32 : s);
    endtask

    task automatic send(input string tag, input longint amb, input longint spk, output longint obs);
        int     lat;
        longint expv;
        bus.ambient_sample_in = 16'(amb);
        bus.speaker_output_in = 16'(spk);
        bus.ready_in = 1'b1;
        exp_q.push_back(model_step(amb, spk));
        lat = 0;
        obs = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            bus.ready_in = 1'b0;
            if (i == 1) check({tag, "_busy"}, bus.busy_out, 1);
            if (bus.done_out) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 8);
        expv = exp_q.pop_front();
        if (lat != 0) obs = bus.feedback_sample_out;
        check({tag, "_data"}, obs, expv);
    endtask

    task automatic impulse_test(input string tag);
        longint obs;
        do_reset(tag);
        for (int n = 0; n < 70; n++) begin
            send(tag, (n == 0) ? 1000 : 0, 0, obs);
            if (n == 64) check({tag, "_s64"}, obs, 500);
            else if (n > 60) check({tag, "_zero"}, obs, 0);
        end
    endtask

    initial begin
        longint obs;
        int     lat;
        int     ndone;
        longint expv;
        rst_n = 1'b0;
        bus.ready_in = 1'b0;
        bus.ambient_sample_in = '0;
        bus.speaker_output_in = '0;
        bus.cfg_we_in = 1'b0;
        bus.cfg_tap_in = '0;
        bus.cfg_delay_in = '0;
        bus.cfg_scale_in = '0;
        repeat (2) @(posedge clk);
        #1;

        impulse_test("t1");

        do_reset("t2");
        cfg(0, 0, 32);
        cfg(1, 1, -16);
        send("t2a", 1000, 0, obs); check("t2a_const", obs, 1000);
        send("t2b", 0, 0, obs);    check("t2b_const", obs, -500);
        send("t2c", 0, 0, obs);    check("t2c_const", obs, 0);

        do_reset("t3");
        cfg(0, 0, 32);
        cfg(1, 0, 32);
        send("t3a", 32767, 32767, obs);   check("t3a_satpos", obs, 32767);
        send("t3b", -32768, -32768, obs); check("t3b_satneg", obs, -32768);
        send("t3c", 100, -50, obs);       check("t3c_mid", obs, 150);

        do_reset("tc");
        cfg(0, 0, 63);
        send("tc_hi", 100, 0, obs); check("tc_hi_const", obs, 100);
        cfg(0, 0, -64);
        send("tc_lo", 100, 0, obs); check("tc_lo_const", obs, -100);

        do_reset("t4");
        cfg(0, 255, 32);
        for (int n = 0; n < 600; n++) begin
            send("t4", longint'($urandom_range(65535)) - 32768, 0, obs);
        end

        do_reset("t5");
        cfg(0, 0, 32);
        bus.ambient_sample_in = 16'sd1234;
        bus.speaker_output_in = 16'sd0;
        bus.ready_in = 1'b1;
        exp_q.push_back(model_step(1234, 0));
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            bus.ready_in = 1'b0;
            if (i == 2) begin
                bus.ready_in = 1'b1;
                bus.ambient_sample_in = 16'sd777;
            end
            if (i == 3) check("t5_overrun", bus.overrun_out, 1);
            if (i == 4) begin
                check("t5_overrun_clear", bus.overrun_out, 0);
                bus.cfg_we_in    = 1'b1;
                bus.cfg_tap_in   = 2'd0;
                bus.cfg_scale_in = 7'sd0;
            end
            if (i == 5) bus.cfg_we_in = 1'b0;
            if (bus.done_out) begin
                lat = i;
                break;
            end
        end
        check("t5_latency", lat, 8);
        expv = exp_q.pop_front();
        check("t5_data", bus.feedback_sample_out, expv);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done_out) ndone++;
        end
        check("t5_no_second_done", ndone, 0);
        send("t5_after", 300, 0, obs);
        check("t5_cfg_ignored", obs, 300);

        do_reset("t6");
        cfg(0, 0, 32);
        send("t6_pre", 2500, 0, obs);
        bus.ambient_sample_in = 16'sd4000;
        bus.ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            bus.ready_in = 1'b0;
        end
        check("t6_busy_in_tap", bus.busy_out, 1);
        do_reset("t6_mid");
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done_out) ndone++;
        end
        check("t6_no_done", ndone, 0);
        check("t6_feedback_zero", bus.feedback_sample_out, 0);
        impulse_test("t6_t1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
